// File: rtl/number_analyzer_pkg.sv
// Shared types and defaults for the number analyzer datapath:
// loader state encoding and default word geometry.
`timescale 1ns/1ps
package number_analyzer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } loader_state_e;

endpackage

// File: rtl/serial_word_loader.sv
// Assembles MSB-first serial bits into WIDTH-bit words and hands each word
// to the downstream palindrome checker with a valid/ready handshake.
`timescale 1ns/1ps
module serial_word_loader
   import number_analyzer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             busy,
   output logic             overrun_err,
   output logic [CNT_W-1:0] word_count
);

   localparam int unsigned BCW = $clog2(WIDTH + 1);

   loader_state_e    state_q, state_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] word_out_q, word_out_d;
   logic             word_valid_q, word_valid_d;
   logic             busy_q, busy_d;
   logic             overrun_err_q, overrun_err_d;
   logic [CNT_W-1:0] word_count_q, word_count_d;
   logic             last_bit;

   // Next-state and registered-output computation
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      word_out_d    = word_out_q;
      word_count_d  = word_count_q;
      overrun_err_d = 1'b0;
      last_bit      = (bit_cnt_q == BCW'(WIDTH - 1));

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
            end
         end
         ST_SHIFT: begin
            // A start mid-frame restarts the frame and drops the coincident bit
            if (start) begin
               bit_cnt_d = '0;
            end else if (bit_valid) begin
               word_out_d = {word_out_q[WIDTH-2:0], bit_in};
               bit_cnt_d  = bit_cnt_q + BCW'(1);
               if (last_bit) state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            overrun_err_d = bit_valid;
            if (out_ready) begin
               word_count_d = word_count_q + CNT_W'(1);
               bit_cnt_d    = '0;
               state_d      = start ? ST_SHIFT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      word_valid_d = (state_d == ST_HOLD);
      busy_d       = (state_d == ST_SHIFT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         word_out_q    <= '0;
         word_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         overrun_err_q <= 1'b0;
         word_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         word_out_q    <= word_out_d;
         word_valid_q  <= word_valid_d;
         busy_q        <= busy_d;
         overrun_err_q <= overrun_err_d;
         word_count_q  <= word_count_d;
      end
   end

   assign word_out    = word_out_q;
   assign word_valid  = word_valid_q;
   assign busy        = busy_q;
   assign overrun_err = overrun_err_q;
   assign word_count  = word_count_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench for serial_word_loader: control table, directed
// multi-cycle sequences and random traffic against a bit-queue reference model.
`timescale 1ns/1ps
module tb_serial_word_loader;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic          bit_valid;
   logic          bit_in;
   logic          out_ready;
   logic [W-1:0]  word_out;
   logic          word_valid;
   logic          busy;
   logic          overrun_err;
   logic [CW-1:0] word_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: 0 = waiting for start, 1 = collecting, 2 = holding a word
   int          m_mode;
   bit          m_bits[$];
   logic [W-1:0] m_word;
   int          m_count;
   bit          m_ovr;

   serial_word_loader #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .out_ready   (out_ready),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .busy        (busy),
      .overrun_err (overrun_err),
      .word_count  (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_mode  = 0;
      m_bits.delete();
      m_word  = '0;
      m_count = 0;
      m_ovr   = 1'b0;
   endfunction

   function automatic void model_step(input bit s, input bit bv, input bit bi, input bit r);
      m_ovr = 1'b0;
      case (m_mode)
         0: if (s) begin
               m_mode = 1;
               m_bits.delete();
            end
         1: if (s) begin
               m_bits.delete();
            end else if (bv) begin
               m_bits.push_back(bi);
               if (m_bits.size() == W) begin
                  m_word = '0;
                  foreach (m_bits[i]) m_word = (m_word << 1) | W'(m_bits[i]);
                  m_mode = 2;
               end
            end
         default: begin
            m_ovr = bv;
            if (r) begin
               m_count = (m_count + 1) % (1 << CW);
               m_mode  = s ? 1 : 0;
               m_bits.delete();
            end
         end
      endcase
   endfunction

   function automatic void compare_all();
      chk("word_valid", 32'(word_valid), 32'(m_mode == 2));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("overrun_err", 32'(overrun_err), 32'(m_ovr));
      chk("word_count", 32'(word_count), 32'(m_count));
      if (m_mode == 2) chk("word_out", word_out, m_word);
   endfunction

   task automatic cyc(input bit s, input bit bv, input bit bi, input bit r);
      start     = s;
      bit_valid = bv;
      bit_in    = bi;
      out_ready = r;
      @(posedge clk);
      #1;
      model_step(s, bv, bi, r);
      compare_all();
   endtask

   task automatic send_word(input logic [W-1:0] w, input int gmin, input int gmax, input bit r);
      for (int i = W - 1; i >= 0; i--) begin
         int g;
         g = (gmax > 0) ? int'($urandom_range(gmax, gmin)) : 0;
         for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, bit'($urandom_range(1, 0)), r);
         cyc(1'b0, 1'b1, w[i], r);
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
   task automatic do_reset();
      #3;
      rst = 1'b1;
      #1;
      chk("rst_word_out", word_out, 32'h0);
      chk("rst_word_valid", 32'(word_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_overrun", 32'(overrun_err), 32'h0);
      chk("rst_word_count", 32'(word_count), 32'h0);
      model_reset();
      start     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();
   endtask

   typedef struct {
      bit s, bv, bi, r;
      bit e_busy, e_valid, e_ovr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{s:0, bv:1, bi:1, r:0, e_busy:0, e_valid:0, e_ovr:0};
      tbl[1] = '{s:0, bv:1, bi:0, r:1, e_busy:0, e_valid:0, e_ovr:0};
      tbl[2] = '{s:1, bv:1, bi:1, r:0, e_busy:1, e_valid:0, e_ovr:0};
      tbl[3] = '{s:0, bv:1, bi:1, r:0, e_busy:1, e_valid:0, e_ovr:0};
      tbl[4] = '{s:1, bv:1, bi:0, r:0, e_busy:1, e_valid:0, e_ovr:0};
      tbl[5] = '{s:0, bv:0, bi:0, r:1, e_busy:1, e_valid:0, e_ovr:0};

      rst       = 1'b1;
      start     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_word_out", word_out, 32'h0);
      chk("init_word_valid", 32'(word_valid), 32'h0);
      chk("init_busy", 32'(busy), 32'h0);
      chk("init_word_count", 32'(word_count), 32'h0);
      rst = 1'b0;

      // Control-path table: idle ignores bits, start enters shift, restart stays busy
      for (int i = 0; i < 6; i++) begin
         start     = tbl[i].s;
         bit_valid = tbl[i].bv;
         bit_in    = tbl[i].bi;
         out_ready = tbl[i].r;
         @(posedge clk);
         #1;
         model_step(tbl[i].s, tbl[i].bv, tbl[i].bi, tbl[i].r);
         chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
         chk("tbl_valid", 32'(word_valid), 32'(tbl[i].e_valid));
         chk("tbl_overrun", 32'(overrun_err), 32'(tbl[i].e_ovr));
      end
      do_reset();

      // Single word, ready already high
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      send_word(32'h8000_0001, 0, 0, 1'b1);
      chk("w1_valid", 32'(word_valid), 32'h1);
      chk("w1_word", word_out, 32'h8000_0001);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("w1_count", 32'(word_count), 32'h1);
      chk("w1_valid_low", 32'(word_valid), 32'h0);

      // Gapped bits; busy checked every cycle by compare_all
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(32'hD261_8649, 1, 3, 1'b0);
      chk("w2_word", word_out, 32'hD261_8649);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Backpressure with bits arriving during hold
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(32'hFFFF_FFFE, 0, 0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, (k == 1) || (k == 3), 1'b1, 1'b0);
         chk("ovr_pulse", 32'(overrun_err), 32'((k == 1) || (k == 3)));
         chk("ovr_word", word_out, 32'hFFFF_FFFE);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("hold_start_ignored", 32'(word_valid), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("w3_count", 32'(word_count), 32'h3);

      // Abort after 10 bits, then a clean frame
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      send_word(32'hFFFE_0000, 0, 0, 1'b0);
      chk("abort_word", word_out, 32'hFFFE_0000);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back delivery through start+ready in hold
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(32'h1234_5678, 0, 0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("b2b_busy", 32'(busy), 32'h1);
      chk("b2b_count1", 32'(word_count), 32'h1);
      send_word(32'h0000_0000, 0, 0, 1'b0);
      chk("b2b_word", word_out, 32'h0);
      chk("b2b_valid", 32'(word_valid), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("b2b_count2", 32'(word_count), 32'h2);

      // Reset mid-shift and mid-hold discards the word
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, bit'(k & 1), 1'b0);
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(32'hA5A5_5A5A, 0, 0, 1'b0);
      do_reset();
      chk("post_rst_count", 32'(word_count), 32'h0);

      // 256 deliveries wrap the counter
      for (int n = 0; n < 256; n++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         send_word(W'($urandom), 0, 0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
      end
      chk("wrap_count", 32'(word_count), 32'h0);

      // Random traffic against the reference model
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         cyc(bit'($urandom_range(99, 0) < 4), bit'($urandom_range(1, 0)),
             bit'($urandom_range(1, 0)), bit'($urandom_range(99, 0) < 30));
         if (n == 2000) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the number of bits per assembled word.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the delivered-word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request that begins a new frame.
REQ-006 SHALL have port bit_valid, input, 1, qualifying bit_in in the current cycle.
REQ-007 SHALL have port bit_in, input, 1, the serial data bit, sent MSB first.
REQ-008 SHALL have port out_ready, input, 1, the downstream analyzer (is_palindrome stage) accepting the word.
REQ-009 SHALL have port word_out, output, WIDTH, the assembled word fed to the palindrome checker.
REQ-010 SHALL have port word_valid, output, 1, asserted while word_out holds a complete, undelivered word.
REQ-011 SHALL have port busy, output, 1, asserted while a frame is being shifted in.
REQ-012 SHALL have port overrun_err, output, 1, a one-cycle pulse when a bit is dropped.
REQ-013 SHALL have port word_count, output, CNT_W, the number of words delivered, wrapping modulo 2^CNT_W.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, HOLD; registered outputs only.
REQ-015 IDLE: start -> SHIFT with bit counter cleared to 0; bit_valid ignored, no error.
REQ-016 SHIFT: each bit_valid cycle does word_out <= {word_out[WIDTH-2:0], bit_in} and counter+1; cycles without bit_valid hold state.
REQ-017 SHIFT: on the WIDTH-th accepted bit -> HOLD; word_valid rises the cycle after that bit, for a latency of 1 clock.
REQ-018 SHIFT: start (with or without bit_valid) aborts the frame, clears the counter, and stays in SHIFT; the coincident bit is discarded.
REQ-019 HOLD: word_valid=1 and word_out stable until the cycle where out_ready=1 (handshake).
REQ-020 HOLD with out_ready=1 and no start -> IDLE; word_valid low next cycle; word_count+1.
REQ-021 HOLD with out_ready=1 and start in the same cycle -> SHIFT directly, counter=0, word_count+1.
REQ-022 HOLD with start and out_ready=0: start ignored, word retained.
REQ-023 HOLD: bit_valid=1 -> overrun_err pulses the next cycle, the bit is dropped, and word_out is unchanged.
REQ-024 busy SHALL be 1 exactly in SHIFT.
REQ-025 word_count SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and never exceed WIDTH.

Reset
REQ-027 On rst, state=IDLE, word_out=0, word_valid=0, busy=0, overrun_err=0, word_count=0, and bit counter=0, immediately and asynchronously.
REQ-028 rst mid-SHIFT or mid-HOLD SHALL discard the partial or held word; no word_count increment.
REQ-029 After rst deasserts, the first start SHALL behave as REQ-015.

Structure
REQ-030 State encoding (IDLE/SHIFT/HOLD) and the default WIDTH SHALL live in shared package number_analyzer_pkg.
REQ-031 SHALL be a single module with no sub-modules; the downstream is_palindrome is instantiated by the top level, not here.

Verification
REQ-032 Shift 0x80000001 MSB-first with out_ready=1 -> word_valid one cycle after bit 32, word_out=0x80000001, word_count=1.
REQ-033 Shift 0xD2618649 with bit_valid gaps of 1-3 cycles -> word_out=0xD2618649; busy high throughout the frame.
REQ-034 Shift 0xFFFFFFFE with out_ready=0 for 5 cycles, pulsing bit_valid in HOLD -> overrun_err pulse, word_out unchanged, delivery when out_ready rises.
REQ-035 After 10 bits, assert start, then shift 0xFFFE0000 -> word_out=0xFFFE0000 with no residue of the aborted bits.
REQ-036 In HOLD, assert start and out_ready together, then shift 0x00000000 -> back-to-back delivery, word_count=2.
REQ-037 Assert rst at bit 16, then in HOLD -> all outputs 0 immediately; deliver 256 words -> word_count wraps to 0.
